// File: rtl/trace_reg_arb.sv
// Arbiter sharing the trace register bus between the USB host frontend (always wins)
// and a local burst requester. Optional preemption counter: TRACE_ARB_PREEMPT_STATS_EN.
module trace_reg_arb #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pMAX_BYTES    = 8
) (
    input  logic                     usb_clk,
    input  logic                     reset_n,
    input  logic [7:0]               host_address,
    input  logic [pBYTECNT_SIZE-1:0] host_bytecnt,
    input  logic [7:0]               host_write_data,
    input  logic                     host_read,
    input  logic                     host_write,
    input  logic                     host_addrvalid,
    output logic [7:0]               host_read_data,
    input  logic                     loc_req,
    input  logic                     loc_rnw,
    input  logic [7:0]               loc_address,
    input  logic [3:0]               loc_len,
    input  logic [63:0]              loc_wdata,
    output logic                     loc_gnt,
    output logic                     loc_done,
    output logic                     loc_err,
    output logic                     loc_busy,
    output logic [63:0]              loc_rdata,
    output logic [15:0]              loc_preempt_count,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    input  logic [7:0]               read_data
);

    typedef enum logic [2:0] {IDLE, SETUP, BEAT, PAUSE, DRAIN, FIN} state_t;

    localparam logic [4:0] MAX_LEN = 5'(pMAX_BYTES);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        rnw_q;
    logic [7:0]  addr_q;
    logic [3:0]  len_q;
    logic [63:0] wdata_q;
    logic        gnt_q, err_q;
    logic        cap_vld_q;
    logic [2:0]  cap_idx_q;

    logic accept, len_ok, preempt, beat_go;
    logic                     l_addrvalid, l_read, l_write;
    logic [7:0]               l_address, l_wdata;
    logic [pBYTECNT_SIZE-1:0] l_bytecnt;

    assign len_ok = (loc_len != 4'd0) && ({1'b0, loc_len} <= MAX_LEN);

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        accept      = 1'b0;
        preempt     = 1'b0;
        beat_go     = 1'b0;
        l_addrvalid = 1'b0;
        l_read      = 1'b0;
        l_write     = 1'b0;
        l_address   = 8'h00;
        l_wdata     = 8'h00;
        l_bytecnt   = '0;
        case (state_q)
            IDLE: begin
                if (loc_req && !host_addrvalid) begin
                    accept  = 1'b1;
                    idx_d   = 4'd0;
                    state_d = len_ok ? SETUP : IDLE;
                end
            end
            SETUP: begin
                if (host_addrvalid) begin
                    preempt = 1'b1;
                    state_d = PAUSE;
                end else begin
                    l_addrvalid = 1'b1;
                    l_address   = addr_q;
                    l_bytecnt   = pBYTECNT_SIZE'(idx_q);
                    state_d     = BEAT;
                end
            end
            BEAT: begin
                // A host cycle turns this beat into a no-op; the index is kept for the resume.
                if (host_addrvalid) begin
                    preempt = 1'b1;
                    state_d = PAUSE;
                end else begin
                    beat_go     = 1'b1;
                    l_addrvalid = 1'b1;
                    l_address   = addr_q;
                    l_bytecnt   = pBYTECNT_SIZE'(idx_q);
                    l_read      = rnw_q;
                    l_write     = ~rnw_q;
                    l_wdata     = rnw_q ? 8'h00 : wdata_q[{idx_q[2:0], 3'b000} +: 8];
                    idx_d       = idx_q + 4'd1;
                    state_d     = ((idx_q + 4'd1) == len_q) ? DRAIN : BEAT;
                end
            end
            PAUSE:   if (!host_addrvalid) state_d = SETUP;
            DRAIN:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read bytes arrive one cycle after their beat, so capture is tracked with a delayed tag.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            rnw_q     <= 1'b0;
            addr_q    <= 8'h00;
            len_q     <= 4'd0;
            wdata_q   <= 64'd0;
            gnt_q     <= 1'b0;
            err_q     <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= 3'd0;
            loc_rdata <= 64'd0;
        end else begin
            gnt_q     <= accept;
            err_q     <= accept & ~len_ok;
            cap_vld_q <= beat_go & rnw_q;
            cap_idx_q <= idx_q[2:0];
            if (accept) begin
                rnw_q     <= loc_rnw;
                addr_q    <= loc_address;
                len_q     <= loc_len;
                wdata_q   <= loc_wdata;
                loc_rdata <= 64'd0;
            end else if (cap_vld_q) begin
                loc_rdata[{cap_idx_q, 3'b000} +: 8] <= read_data;
            end
        end
    end

`ifdef TRACE_ARB_PREEMPT_STATS_EN
    logic [15:0] pcnt_q;

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n)
            pcnt_q <= 16'h0000;
        else if (preempt && (pcnt_q != 16'hFFFF))
            pcnt_q <= pcnt_q + 16'd1;
    end

    assign loc_preempt_count = pcnt_q;
`else
    assign loc_preempt_count = 16'h0000;
`endif

    assign loc_gnt  = gnt_q;
    assign loc_err  = err_q;
    assign loc_done = (state_q == FIN);
    assign loc_busy = (state_q != IDLE);

    assign host_read_data = read_data;
    assign reg_addrvalid  = host_addrvalid ? 1'b1            : l_addrvalid;
    assign reg_address    = host_addrvalid ? host_address    : l_address;
    assign reg_bytecnt    = host_addrvalid ? host_bytecnt    : l_bytecnt;
    assign write_data     = host_addrvalid ? host_write_data : l_wdata;
    assign reg_read       = host_addrvalid ? host_read       : l_read;
    assign reg_write      = host_addrvalid ? host_write      : l_write;

endmodule
